// File: rtl/sprite_draw.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite from ROM in raster order and
// writes every opaque, on-screen pixel to the frame buffer.
module sprite_draw #(
    parameter int unsigned SPR_W       = 16,
    parameter int unsigned SPR_H       = 16,
    parameter logic [8:0]  TRANSPARENT = 9'h1FF,
    parameter int unsigned SCREEN_W    = 320,
    parameter int unsigned SCREEN_H    = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] x_pos,
    input  logic [7:0] y_pos,
    input  logic [1:0] frame,
    output logic [9:0] rom_addr,
    input  logic [8:0] rom_data,
    output logic [8:0] fb_x,
    output logic [7:0] fb_y,
    output logic [8:0] fb_color,
    output logic       fb_we,
    output logic       done
);

    localparam int unsigned COL_W = $clog2(SPR_W);
    localparam int unsigned ROW_W = $clog2(SPR_H);
    localparam int unsigned CNT_W = COL_W + ROW_W;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [9:0] SCR_X = 10'(SCREEN_W);
    localparam logic [8:0] SCR_Y = 9'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       x_q;
    logic [7:0]       y_q;
    logic [1:0]       frame_q;
    logic             pipe_valid;
    logic [ROW_W-1:0] pipe_row;
    logic [COL_W-1:0] pipe_col;

    logic [9:0] sum_x;
    logic [8:0] sum_y;
    logic       on_screen;

    // Control FSM, address generator and the one-stage tag pipeline that
    // lines the issued row/col up with the ROM read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            rom_addr   <= '0;
            pipe_valid <= 1'b0;
            pipe_row   <= '0;
            pipe_col   <= '0;
            done       <= 1'b0;
        end else begin
            pipe_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q      <= x_pos;
                        y_q      <= y_pos;
                        frame_q  <= frame;
                        cnt      <= '0;
                        rom_addr <= 10'({frame, CNT_W'(0)});
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    pipe_valid <= 1'b1;
                    pipe_row   <= cnt[CNT_W-1:COL_W];
                    pipe_col   <= cnt[COL_W-1:0];
                    cnt        <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_FLUSH;
                    end else begin
                        rom_addr <= 10'({frame_q, cnt + CNT_W'(1)});
                    end
                end
                S_FLUSH: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A held start must fall before the next draw can begin.
                    if (!start) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sums are one bit wider than the ports so a carry clips instead of wrapping.
    always_comb begin
        sum_x     = 10'(x_q) + 10'(pipe_col);
        sum_y     = 9'(y_q) + 9'(pipe_row);
        on_screen = (sum_x < SCR_X) && (sum_y < SCR_Y);
        fb_we     = pipe_valid && (rom_data != TRANSPARENT) && on_screen;
        fb_x      = sum_x[8:0];
        fb_y      = sum_y[7:0];
        fb_color  = pipe_valid ? rom_data : 9'h000;
    end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: ROM model, write capture and per-scenario checks.
module tb_sprite_draw;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] x_pos;
    logic [7:0] y_pos;
    logic [1:0] frame;
    logic [9:0] rom_addr;
    logic [8:0] rom_data = 9'h000;
    logic [8:0] fb_x;
    logic [7:0] fb_y;
    logic [8:0] fb_color;
    logic       fb_we;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    // Captured draw
    int         wx [256];
    int         wy [256];
    int         wc [256];
    int         wt [256];
    int         nwr;
    int         done_cnt;
    int         done_c;
    logic [9:0] raddr [300];

    // Expected draw
    int ex [256];
    int ey [256];
    int ec [256];
    int et [256];
    int ne;

    sprite_draw dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .frame    (frame),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_x     (fb_x),
        .fb_y     (fb_y),
        .fb_color (fb_color),
        .fb_we    (fb_we),
        .done     (done)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] rom_model(input logic [9:0] a);
        case (a[9:8])
            2'd0:    return a[0] ? 9'h003 : 9'h1FF;
            2'd1:    return 9'h0AA;
            2'd2:    return {1'b0, a[7:0]};
            default: return {2'b10, a[6:0]};
        endcase
    endfunction

    always @(posedge clock) rom_data <= rom_model(rom_addr);

    task automatic build_expected(input int x, input int y, input int fr);
        logic [9:0] a;
        logic [8:0] c;
        ne = 0;
        for (int row = 0; row < 16; row++) begin
            for (int col = 0; col < 16; col++) begin
                a = 10'(fr * 256 + row * 16 + col);
                c = rom_model(a);
                if (c != 9'h1FF && x + col < 320 && y + row < 240) begin
                    ex[ne] = x + col;
                    ey[ne] = y + row;
                    ec[ne] = int'(c);
                    et[ne] = 1 + row * 16 + col;
                    ne++;
                end
            end
        end
    endtask

    function automatic int pixel_errs();
        int n;
        int e;
        n = (nwr < ne) ? nwr : ne;
        if (n > 256) n = 256;
        e = (nwr > ne) ? nwr - ne : ne - nwr;
        for (int i = 0; i < n; i++) begin
            if (wx[i] != ex[i] || wy[i] != ey[i] || wc[i] != ec[i] || wt[i] != et[i]) e++;
        end
        return e;
    endfunction

    function automatic int addr_errs(input int fr);
        int e;
        logic [9:0] exp_a;
        e = 0;
        for (int c = 0; c < 256; c++) begin
            exp_a = 10'(fr * 256 + c);
            if (raddr[c] !== exp_a) e++;
        end
        return e;
    endfunction

    // Starts a draw (E0 = next rising edge) and records every cycle after it.
    task automatic draw_capture(input int x, input int y, input int fr,
                                input int drop_at, input int total);
        nwr = 0;
        done_cnt = 0;
        done_c = -1;
        x_pos = 9'(x);
        y_pos = 8'(y);
        frame = 2'(fr);
        start = 1'b1;
        @(posedge clock);
        for (int c = 0; c < total; c++) begin
            @(negedge clock);
            if (c < 300) raddr[c] = rom_addr;
            if (fb_we === 1'b1) begin
                if (nwr < 256) begin
                    wx[nwr] = int'(fb_x);
                    wy[nwr] = int'(fb_y);
                    wc[nwr] = int'(fb_color);
                    wt[nwr] = c;
                end
                nwr++;
            end
            if (done === 1'b1) begin
                if (done_c < 0) done_c = c;
                done_cnt++;
            end
            if (c == drop_at) start = 1'b0;
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        start = 1'b0;
        x_pos = 9'h155;
        y_pos = 8'hAA;
        frame = 2'd3;
        repeat (2) @(negedge clock);
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we got %b want 0", fb_we); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (rom_addr !== 10'd0) begin miscompares++; $display("FAIL reset_rom_addr got %h want 000", rom_addr); end
        vectors++; if (fb_x !== 9'd0) begin miscompares++; $display("FAIL reset_fb_x got %h want 000", fb_x); end
        vectors++; if (fb_y !== 8'd0) begin miscompares++; $display("FAIL reset_fb_y got %h want 00", fb_y); end
        vectors++; if (fb_color !== 9'd0) begin miscompares++; $display("FAIL reset_fb_color got %h want 000", fb_color); end
        reset = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (fb_we !== 1'b0 || done !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL idle_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_opaque();
        draw_capture(100, 50, 1, -1, 262);
        build_expected(100, 50, 1);
        vectors++; if (nwr !== 256) begin miscompares++; $display("FAIL opaque_count got %0d want 256", nwr); end
        vectors++; if (pixel_errs() !== 0) begin miscompares++; $display("FAIL opaque_pixels got %0d bad want 0", pixel_errs()); end
        vectors++; if (wx[0] !== 100 || wy[0] !== 50 || wt[0] !== 1) begin miscompares++; $display("FAIL opaque_first got (%0d,%0d)@%0d want (100,50)@1", wx[0], wy[0], wt[0]); end
        vectors++; if (wx[255] !== 115 || wy[255] !== 65 || wc[255] !== 'h0AA) begin miscompares++; $display("FAIL opaque_last got (%0d,%0d,%h) want (115,65,0aa)", wx[255], wy[255], wc[255]); end
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL opaque_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
        vectors++; if (addr_errs(1) !== 0) begin miscompares++; $display("FAIL opaque_addr got %0d bad want 0", addr_errs(1)); end
    endtask

    task automatic test_transparency();
        draw_capture(0, 0, 0, -1, 262);
        build_expected(0, 0, 0);
        vectors++; if (nwr !== 128) begin miscompares++; $display("FAIL transp_count got %0d want 128", nwr); end
        vectors++; if (pixel_errs() !== 0) begin miscompares++; $display("FAIL transp_pixels got %0d bad want 0", pixel_errs()); end
        vectors++; if (wx[0] !== 1 || wt[0] !== 2 || wc[0] !== 3) begin miscompares++; $display("FAIL transp_first got x=%0d @%0d c=%h want x=1 @2 c=003", wx[0], wt[0], wc[0]); end
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL transp_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
    endtask

    task automatic test_clipping();
        draw_capture(310, 230, 1, -1, 262);
        build_expected(310, 230, 1);
        vectors++; if (nwr !== 100) begin miscompares++; $display("FAIL clip_count got %0d want 100", nwr); end
        vectors++; if (pixel_errs() !== 0) begin miscompares++; $display("FAIL clip_pixels got %0d bad want 0", pixel_errs()); end
        vectors++; if (wx[99] !== 319 || wy[99] !== 239 || wt[99] !== 154) begin miscompares++; $display("FAIL clip_last got (%0d,%0d)@%0d want (319,239)@154", wx[99], wy[99], wt[99]); end
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL clip_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
        draw_capture(500, 250, 2, -1, 262);
        vectors++; if (nwr !== 0) begin miscompares++; $display("FAIL clip_wrap_count got %0d want 0", nwr); end
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL clip_wrap_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
    endtask

    task automatic test_hold_rearm();
        draw_capture(20, 30, 2, 278, 285);
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL hold_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
        vectors++; if (nwr !== 256) begin miscompares++; $display("FAIL hold_count got %0d want 256", nwr); end
        draw_capture(40, 60, 3, -1, 262);
        build_expected(40, 60, 3);
        vectors++; if (nwr !== 256) begin miscompares++; $display("FAIL rearm_count got %0d want 256", nwr); end
        vectors++; if (pixel_errs() !== 0) begin miscompares++; $display("FAIL rearm_pixels got %0d bad want 0", pixel_errs()); end
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL rearm_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
    endtask

    task automatic test_reset_mid();
        int bad;
        x_pos = 9'd200;
        y_pos = 8'd100;
        frame = 2'd1;
        start = 1'b1;
        @(posedge clock);
        for (int c = 0; c <= 100; c++) @(negedge clock);
        vectors++; if (fb_we !== 1'b1) begin miscompares++; $display("FAIL mid_pre_we got %b want 1", fb_we); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (fb_we !== 1'b0 || done !== 1'b0 || rom_addr !== 10'd0) begin miscompares++; $display("FAIL mid_async got we=%b done=%b addr=%h want 0 0 000", fb_we, done, rom_addr); end
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (fb_we !== 1'b0 || done !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL mid_in_reset got %0d active cycles want 0", bad); end
        #2 reset = 1'b1;
        draw_capture(200, 100, 1, -1, 262);
        build_expected(200, 100, 1);
        vectors++; if (pixel_errs() !== 0 || nwr !== 256) begin miscompares++; $display("FAIL mid_redraw got %0d writes %0d bad want 256 0", nwr, pixel_errs()); end
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL mid_redraw_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
    endtask

    task automatic test_early_drop();
        draw_capture(64, 32, 2, 50, 262);
        vectors++; if (addr_errs(2) !== 0) begin miscompares++; $display("FAIL drop_addr got %0d bad want 0", addr_errs(2)); end
        vectors++; if (nwr !== 256) begin miscompares++; $display("FAIL drop_count got %0d want 256", nwr); end
        vectors++; if (done_cnt !== 1 || done_c !== 258) begin miscompares++; $display("FAIL drop_done got %0d pulses @%0d want 1 @258", done_cnt, done_c); end
    endtask

    initial begin
        test_reset();
        test_opaque();
        test_transparency();
        test_clipping();
        test_hold_rearm();
        test_reset_mid();
        test_early_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_draw.md
SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 Parameter SPR_W, default 16, sprite width in pixels (power of two).
REQ-002 Parameter SPR_H, default 16, sprite height in pixels (power of two).
REQ-003 Parameter TRANSPARENT, default 9'h1FF, colour code never written to the frame buffer.
REQ-004 Parameter SCREEN_W, default 320, visible width in pixels; SCREEN_H, default 240, visible height in pixels.
REQ-005 clock  input  1  single system clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  level request from the game control FSM, held high for the whole draw state.
REQ-008 x_pos  input  9  sprite top-left x; y_pos  input  8  sprite top-left y.
REQ-009 frame  input  2  sprite frame select (facing/animation).
REQ-010 rom_addr  output  10  sprite ROM address = {frame, row[3:0], col[3:0]}.
REQ-011 rom_data  input  9  ROM colour, valid exactly one cycle after rom_addr.
REQ-012 fb_x  output  9, fb_y  output  8, fb_color  output  9  frame-buffer write pixel.
REQ-013 fb_we  output  1  frame-buffer write strobe.
REQ-014 done  output  1  one-cycle completion pulse back to the control FSM.

Function
REQ-015 States: S_IDLE, S_RUN, S_FLUSH, S_DONE, S_WAIT; encoding is free.
REQ-016 S_IDLE with start=1 at a clock edge: latch x_pos, y_pos and frame; clear the pixel counter to 0; go to S_RUN.
REQ-017 Inputs x_pos, y_pos and frame are ignored outside that latching edge.
REQ-018 S_RUN: rom_addr is driven from the latched frame and the 8-bit counter (row = cnt[7:4], col = cnt[3:0]); the counter increments every cycle.
REQ-019 A one-stage pipeline register carries valid, row and col alongside each issued address, so it lines up with rom_data.
REQ-020 S_RUN with cnt=255 goes to S_FLUSH; S_FLUSH emits the final write and goes to S_DONE.
REQ-021 fb_we is high only when all of the following hold:
  - the pipeline is valid;
  - rom_data != TRANSPARENT;
  - latched_x + col < SCREEN_W;
  - latched_y + row < SCREEN_H.
REQ-022 The coordinate sums are computed at 10/9 bits, so overflow counts as off-screen (clipped) and never wraps.
REQ-023 fb_x = latched_x + col and fb_y = latched_y + row, truncated to port width; fb_color = rom_data.
REQ-024 fb_x, fb_y and fb_color are don't-care when fb_we=0.
REQ-025 S_DONE: done=1 for exactly one cycle; next state is S_WAIT.
REQ-026 S_WAIT: stay while start=1; go to S_IDLE when start=0.
REQ-027 A held start therefore never retriggers a second draw.
REQ-028 Latency: with start sampled high at edge E0, done is high in the cycle after edge E0+258.
REQ-029 First possible fb_we is in the cycle after edge E0+1.
REQ-030 At most 256 writes are made per draw, in raster order: row-major, col fastest.
REQ-031 start falling during S_RUN or S_FLUSH is ignored; the draw completes and done still pulses.
REQ-032 start rising in the same cycle as done is not a new request; a new draw needs start low for at least one edge first.
REQ-033 rom_addr holds its last value outside S_RUN; it is never X.

Reset
REQ-034 reset=0 immediately forces S_IDLE, whatever the clock.
REQ-035 During reset: fb_we=0, done=0, counter=0, pipeline valid=0.
REQ-036 During reset: latched x, y and frame are 0; rom_addr=0; fb_x=0, fb_y=0, fb_color=0.
REQ-037 Reset asserted mid-draw aborts with no further writes and no done pulse.
REQ-038 After reset deasserts, the first draw needs a fresh start=1 sample.

Verification
REQ-039 Opaque sprite: x=100, y=50, frame=1, ROM all 9'h0AA, start held.
  -> 256 writes covering (100..115, 50..65); first write (100,50), last write (115,65); done exactly once, 258 edges after start.
REQ-040 Transparency: frame 0 with even cols = 9'h1FF, odd cols = 9'h003, at (0,0).
  -> 128 writes, odd x only; done timing unchanged.
REQ-041 Clipping: x=310, y=230.
  -> writes only for x 310..319 and y 230..239 (100 writes); no wrapped coordinates; done still pulses.
REQ-042 Hold and rearm: start held 20 cycles past done.
  -> single done, no extra writes; drop start 1 cycle, raise again -> second full draw.
REQ-043 Reset mid-draw: reset=0 at counter 100, async between edges.
  -> fb_we falls immediately, no done; after release with start=1 a full 256-pixel draw follows.
REQ-044 Early start drop: start=0 at counter 50.
  -> draw still completes with 256 addresses issued and done pulses once.
